ifetch_resp: RTL and testbench
==============================

// Module: ifetch_resp
// PURPOSE
//  Responder on the fetch-request interface that the PC generator drives (pc + inst_rreq).
//  Uncached instruction fetch path:
//   - takes one 8-byte fetch per accepted request and issues a 2-beat AXI read burst;
//   - returns the instruction pair to decode and holds the PC via stall while busy.
//  Sits between PC generation and decode, in parallel with the icache.
//  Flushes discard in-flight data without breaking the AXI protocol.
// PARAMETERS
//  ID_W       4      width of arid/rid
//  FETCH_ID   4'd0   arid driven on every burst; beats with another rid are ignored
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   asynchronous, active-high reset
//  inst_rreq      in   1   fetch request from PC unit, valid this cycle
//  pc             in   32  fetch address (start of 8-byte pair)
//  flush          in   1   backend redirect; kill current fetch
//  stall          out  1   hold PC; high whenever state != IDLE
//  out_valid      out  1   instruction pair valid to decode
//  out_ready      in   1   decode accepts pair
//  out_pc         out  32  pc of inst0 (inst1 at out_pc+4)
//  out_inst0      out  32  instruction at out_pc
//  out_inst1      out  32  instruction at out_pc+4
//  out_excp       out  1   fetch exception (ADEF)
//  out_excp_cause out  7   `EXCEPTION_ADEF when out_excp, else `EXCEPTION_NOP
//  arvalid/arready     out/in  1   AXI AR handshake
//  araddr         out  32  burst start address = captured pc
//  arid           out  ID_W FETCH_ID
//  arlen/arsize/arburst out 8/3/2  fixed 8'd1, 3'b010, 2'b01 (INCR)
//  rvalid/rready  in/out 1  AXI R handshake
//  rdata          in   32  read beat
//  rid            in   ID_W read id
//  rlast          in   1   last beat
// BEHAVIOUR
//  Reset: state=IDLE; stall, out_valid, arvalid, rready, out_excp = 0; out_* data = 0; discard=0.
//  States: IDLE, AR, R0, R1, OUT, DRAIN.
//  IDLE:
//   - inst_rreq & !flush: capture pc.
//   - pc[1:0]!=0 -> OUT next cycle: out_excp=1, cause ADEF, inst0/1=0; no AXI access.
//   - else -> AR.
//   - No request accepted in a cycle where flush=1.
//  AR:
//   - arvalid=1, araddr held stable until arready (no AXI withdrawal).
//   - Handshake -> R0, or -> DRAIN if discard is set.
//  R0:
//   - rready=1; beat with rid==FETCH_ID -> inst0, go R1.
//  R1:
//   - rready=1; matching beat -> inst1, go OUT.
//   - rlast on the first beat is a protocol error: go OUT with inst1=0.
//  OUT:
//   - out_valid=1, data held stable until out_ready.
//   - Handshake -> IDLE; stall deasserts in that cycle.
//  DRAIN:
//   - rready=1; swallow matching beats until rlast -> IDLE.
//   - Nothing is presented to decode.
//  flush (highest priority over all transitions except AXI obligations):
//   - IDLE: no effect.
//   - AR before handshake: set discard; stay until arready, then DRAIN.
//   - R0 / R1: -> DRAIN, keeping the count of beats still owed; R1 with rlast in the same cycle -> IDLE.
//   - OUT: drop out_valid next cycle -> IDLE, even if out_ready is also high.
//  Latency, no wait states: req at T -> arvalid T+1 -> beats T+2, T+3 -> out_valid T+4.
//  Minimum 5-cycle issue interval per request.
//  Reset mid-burst: all state cleared immediately; the outstanding burst is the interconnect's concern (system reset).
//  out_* change only on entry to OUT.
//  stall is combinational from state only, so no path from flush to stall.
// TESTING
//  1. Basic: pc=0x1c000000 req, arready at once, beats 0xAAAA0001 then 0xBBBB0002 -> out_valid at T+4 with out_pc=0x1c000000, inst0=0xAAAA0001, inst1=0xBBBB0002; stall high T+1..T+4.
//  2. Backpressure: out_ready low 3 cycles -> out_* stable, stall stays 1, no new AR issued.
//  3. Misaligned: pc=0x1c000002 -> no arvalid, OUT at T+1 with out_excp=1 and cause ADEF.
//  4. Flush after AR handshake, before beat0 -> both beats consumed with rready=1, out_valid never 1.
//     Next request pc=0x1c000100 fetched correctly.
//  5. Flush while AR pending, arready delayed 4 cycles -> araddr stable throughout, then DRAIN of 2 beats, back to IDLE.
//  6. Async reset pulse while in R1 -> all outputs 0 before next edge; rid!=FETCH_ID beats ignored in R0.

Source files
------------

// File: rtl/ifetch_resp.sv
// Uncached instruction-fetch responder: one 8-byte fetch per request, served by a
// 2-beat AXI INCR read burst, with flush handling that never abandons a burst mid-flight.
module ifetch_resp #(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] FETCH_ID  = '0,
    parameter logic [6:0]      EXCP_ADEF = 7'h08,
    parameter logic [6:0]      EXCP_NOP  = 7'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_rreq,
    input  logic [31:0]     pc,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_inst0,
    output logic [31:0]     out_inst1,
    output logic            out_excp,
    output logic [6:0]      out_excp_cause,
    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [ID_W-1:0] arid,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     rdata,
    input  logic [ID_W-1:0] rid,
    input  logic            rlast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R0,
        S_R1,
        S_OUT,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] beat0_q, beat0_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst0_q, out_inst0_d;
    logic [31:0] out_inst1_q, out_inst1_d;
    logic        out_excp_q, out_excp_d;
    logic        beat;

    // Beats carrying another id belong to someone else; they are accepted but ignored.
    assign beat = rvalid && (rid == FETCH_ID);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        beat0_d     = beat0_q;
        out_pc_d    = out_pc_q;
        out_inst0_d = out_inst0_q;
        out_inst1_d = out_inst1_q;
        out_excp_d  = out_excp_q;
        case (state_q)
            S_IDLE: begin
                discard_d = 1'b0;
                if (inst_rreq && !flush) begin
                    pc_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        state_d     = S_OUT;
                        out_pc_d    = pc;
                        out_inst0_d = '0;
                        out_inst1_d = '0;
                        out_excp_d  = 1'b1;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                // The address phase cannot be withdrawn, so a flush only marks the burst for draining.
                if (flush) discard_d = 1'b1;
                if (arready) begin
                    state_d   = (discard_q || flush) ? S_DRAIN : S_R0;
                    discard_d = 1'b0;
                end
            end
            S_R0: begin
                if (beat) beat0_d = rdata;
                if (flush) begin
                    state_d = (beat && rlast) ? S_IDLE : S_DRAIN;
                end else if (beat && rlast) begin
                    state_d     = S_OUT;
                    out_pc_d    = pc_q;
                    out_inst0_d = rdata;
                    out_inst1_d = '0;
                    out_excp_d  = 1'b0;
                end else if (beat) begin
                    state_d = S_R1;
                end
            end
            S_R1: begin
                if (flush) begin
                    state_d = (beat && rlast) ? S_IDLE : S_DRAIN;
                end else if (beat) begin
                    state_d     = S_OUT;
                    out_pc_d    = pc_q;
                    out_inst0_d = beat0_q;
                    out_inst1_d = rdata;
                    out_excp_d  = 1'b0;
                end
            end
            S_OUT: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (beat && rlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            discard_q   <= 1'b0;
            beat0_q     <= '0;
            out_pc_q    <= '0;
            out_inst0_q <= '0;
            out_inst1_q <= '0;
            out_excp_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            beat0_q     <= beat0_d;
            out_pc_q    <= out_pc_d;
            out_inst0_q <= out_inst0_d;
            out_inst1_q <= out_inst1_d;
            out_excp_q  <= out_excp_d;
        end
    end

    // stall depends on state alone, keeping flush off the PC-hold path.
    assign stall          = (state_q != S_IDLE);
    assign out_valid      = (state_q == S_OUT);
    assign arvalid        = (state_q == S_AR);
    assign rready         = (state_q == S_R0) || (state_q == S_R1) || (state_q == S_DRAIN);
    assign araddr         = pc_q;
    assign arid           = FETCH_ID;
    assign arlen          = 8'd1;
    assign arsize         = 3'b010;
    assign arburst        = 2'b01;
    assign out_pc         = out_pc_q;
    assign out_inst0      = out_inst0_q;
    assign out_inst1      = out_inst1_q;
    assign out_excp       = out_excp_q;
    assign out_excp_cause = out_excp_q ? EXCP_ADEF : EXCP_NOP;

endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: directed timing cases plus a randomized run against a
// transaction-level model (one live fetch, one owed burst) and an AXI slave.
module tb_ifetch_resp;

    localparam logic [6:0] EXCP_ADEF  = 7'h08;
    localparam logic [6:0] EXCP_NOP   = 7'h00;
    localparam logic [3:0] FETCH_ID   = 4'd0;
    localparam logic [3:0] FOREIGN_ID = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_rreq = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        stall, out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_inst0, out_inst1;
    logic        out_excp;
    logic [6:0]  out_excp_cause;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [3:0]  rid = '0;
    logic        rlast = 1'b0;

    always #5 clk = ~clk;

    ifetch_resp #(
        .ID_W(4), .FETCH_ID(FETCH_ID), .EXCP_ADEF(EXCP_ADEF), .EXCP_NOP(EXCP_NOP)
    ) dut (
        .clk(clk), .rst(rst), .inst_rreq(inst_rreq), .pc(pc), .flush(flush),
        .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_excp(out_excp), .out_excp_cause(out_excp_cause),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rlast(rlast)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n_deliv = 0;
    int n_rbeats = 0;

    // slave knobs
    int          ar_dly = 0;
    int          gap_pct = 0;
    int          foreign_pct = 0;
    bit          ov_en = 1'b0;
    bit          lastfirst = 1'b0;
    logic [31:0] ov0 = '0;
    logic [31:0] ov1 = '0;

    // reference model state
    bit          req_live = 1'b0;
    bit          axi_owed = 1'b0;
    bit          ar_done = 1'b0;
    int          beat_idx = 0;
    int          ar_wait = 0;
    logic [31:0] owed_addr = '0;
    logic [31:0] exp_pc = '0, exp_i0 = '0, exp_i1 = '0;
    bit          exp_exc = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] h_pc = '0, h_i0 = '0, h_i1 = '0;
    bit          ar_hs_s = 1'b0, r_hs_s = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1C0DE000;
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int idx);
        if (ov_en) return (idx == 0) ? ov0 : ov1;
        return mem_word(a + 32'(idx) * 32'd4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        tick();
        inst_rreq = 1'b1;
        pc = a;
        tick();
        inst_rreq = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int i = 0;
        @(negedge clk);
        while (!out_valid && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int i = 0;
        @(negedge clk);
        while (stall && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_idle", 32'(stall), 32'd0);
    endtask

    // Model + AXI slave: observe at negedge, drive slave inputs just after posedge.
    initial begin : bfm
        forever begin
            @(negedge clk);
            if (rst) begin
                req_live = 0; axi_owed = 0; ar_done = 0; beat_idx = 0; hold = 0;
                ar_wait = 0; ar_hs_s = 0; r_hs_s = 0; rvalid = 1'b0; arready = 1'b0;
            end else begin
                check("stall", 32'(stall), 32'(req_live || axi_owed));
                check("arvalid", 32'(arvalid), 32'(axi_owed && !ar_done));
                check("rready", 32'(rready), 32'(axi_owed && ar_done));
                check("out_valid", 32'(out_valid), 32'(req_live && !axi_owed));
                if (arvalid) check("araddr", araddr, owed_addr);
                if (hold) begin
                    check("hold_pc", out_pc, h_pc);
                    check("hold_inst0", out_inst0, h_i0);
                    check("hold_inst1", out_inst1, h_i1);
                end
                if (out_valid && out_ready && !flush) begin
                    n_deliv++;
                    check("out_pc", out_pc, exp_pc);
                    check("out_inst0", out_inst0, exp_i0);
                    check("out_inst1", out_inst1, exp_i1);
                    check("out_excp", 32'(out_excp), 32'(exp_exc));
                    check("out_cause", 32'(out_excp_cause), 32'(exp_exc ? EXCP_ADEF : EXCP_NOP));
                    $display("xfer %0d pc=%08h inst0=%08h inst1=%08h excp=%0d",
                             n_deliv, out_pc, out_inst0, out_inst1, out_excp);
                end
                ar_hs_s = arvalid && arready;
                r_hs_s  = rvalid && rready;
                if (ar_hs_s) begin
                    check("arid", 32'(arid), 32'(FETCH_ID));
                    check("arlen", 32'(arlen), 32'd1);
                    check("arsize", 32'(arsize), 32'd2);
                    check("arburst", 32'(arburst), 32'd1);
                    ar_done = 1;
                    ar_wait = 0;
                end
                if (r_hs_s && rid == FETCH_ID) begin
                    n_rbeats++;
                    if (rlast) begin
                        axi_owed = 0; ar_done = 0; beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                hold = out_valid && !out_ready && !flush;
                h_pc = out_pc; h_i0 = out_inst0; h_i1 = out_inst1;
                if ((out_valid && out_ready) || flush) req_live = 0;
                if (inst_rreq && !flush && !stall) begin
                    req_live = 1;
                    exp_pc   = pc;
                    exp_exc  = (pc[1:0] != 2'b00);
                    if (exp_exc) begin
                        exp_i0 = '0;
                        exp_i1 = '0;
                    end else begin
                        exp_i0    = beat_data(pc, 0);
                        exp_i1    = lastfirst ? 32'd0 : beat_data(pc, 1);
                        axi_owed  = 1; ar_done = 0; beat_idx = 0;
                        owed_addr = pc;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                if (arvalid) begin
                    if (ar_wait >= ar_dly) arready = 1'b1;
                    else begin
                        arready = 1'b0;
                        ar_wait++;
                    end
                end else begin
                    arready = 1'b0;
                end
                if (!(rvalid && !r_hs_s)) begin
                    if (axi_owed && ar_done && $urandom_range(0, 99) >= 32'(gap_pct)) begin
                        rvalid = 1'b1;
                        if ($urandom_range(0, 99) < 32'(foreign_pct)) begin
                            rid   = FOREIGN_ID;
                            rdata = $urandom();
                            rlast = 1'($urandom_range(0, 1));
                        end else begin
                            rid   = FETCH_ID;
                            rdata = beat_data(owed_addr, beat_idx);
                            rlast = lastfirst || (beat_idx == 1);
                        end
                    end else begin
                        rvalid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

    initial begin : main
        int b0;
        logic [31:0] r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_excp", 32'(out_excp), 32'd0);
        check("rst_cause", 32'(out_excp_cause), 32'(EXCP_NOP));
        check("rst_out_inst0", out_inst0, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        tick();
        rst = 1'b0;

        // basic latency with fixed beat data
        ov_en = 1'b1; ov0 = 32'hAAAA0001; ov1 = 32'hBBBB0002;
        tick();
        inst_rreq = 1'b1; pc = 32'h1C000000;
        @(negedge clk);
        check("t1_stall_T", 32'(stall), 32'd0);
        tick();
        inst_rreq = 1'b0;
        @(negedge clk);
        check("t1_arvalid_T1", 32'(arvalid), 32'd1);
        check("t1_araddr_T1", araddr, 32'h1C000000);
        check("t1_stall_T1", 32'(stall), 32'd1);
        tick(); @(negedge clk);
        check("t1_rready_T2", 32'(rready), 32'd1);
        check("t1_valid_T2", 32'(out_valid), 32'd0);
        tick(); @(negedge clk);
        check("t1_valid_T3", 32'(out_valid), 32'd0);
        check("t1_stall_T3", 32'(stall), 32'd1);
        tick(); @(negedge clk);
        check("t1_valid_T4", 32'(out_valid), 32'd1);
        check("t1_pc_T4", out_pc, 32'h1C000000);
        check("t1_inst0_T4", out_inst0, 32'hAAAA0001);
        check("t1_inst1_T4", out_inst1, 32'hBBBB0002);
        check("t1_stall_T4", 32'(stall), 32'd1);
        tick(); @(negedge clk);
        check("t1_stall_T5", 32'(stall), 32'd0);
        ov_en = 1'b0;

        // decode backpressure
        tick();
        out_ready = 1'b0; inst_rreq = 1'b1; pc = 32'h1C000040;
        tick();
        inst_rreq = 1'b0;
        wait_valid(20);
        repeat (3) begin
            tick(); @(negedge clk);
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_stall", 32'(stall), 32'd1);
            check("t2_no_ar", 32'(arvalid), 32'd0);
            check("t2_inst1", out_inst1, mem_word(32'h1C000044));
        end
        tick();
        out_ready = 1'b1;
        wait_idle(10);

        // misaligned pc raises ADEF without touching AXI
        tick();
        inst_rreq = 1'b1; pc = 32'h1C000002;
        @(negedge clk);
        tick();
        inst_rreq = 1'b0;
        @(negedge clk);
        check("t3_no_ar", 32'(arvalid), 32'd0);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_excp", 32'(out_excp), 32'd1);
        check("t3_cause", 32'(out_excp_cause), 32'(EXCP_ADEF));
        check("t3_inst0", out_inst0, 32'd0);
        tick(); @(negedge clk);
        check("t3_idle", 32'(stall), 32'd0);

        // rlast on the first beat: pair delivered with inst1 zeroed
        lastfirst = 1'b1;
        issue(32'h1C000080);
        wait_valid(20);
        check("lf_inst0", out_inst0, mem_word(32'h1C000080));
        check("lf_inst1", out_inst1, 32'd0);
        wait_idle(10);
        lastfirst = 1'b0;

        // flush after AR handshake: burst drained, nothing delivered
        issue(32'h1C000300);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("t4_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        wait_idle(10);
        issue(32'h1C000100);
        wait_valid(20);
        check("t4_next_pc", out_pc, 32'h1C000100);
        check("t4_next_inst0", out_inst0, mem_word(32'h1C000100));
        check("t4_next_inst1", out_inst1, mem_word(32'h1C000104));
        wait_idle(10);

        // flush while AR waits on a slow arready
        ar_dly = 4;
        b0 = n_rbeats;
        issue(32'h1C000200);
        flush = 1'b1;
        @(negedge clk);
        check("t5_arvalid", 32'(arvalid), 32'd1);
        tick();
        flush = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("t5_no_valid", 32'(out_valid), 32'd0);
            if (arvalid) check("t5_araddr", araddr, 32'h1C000200);
            tick();
        end
        @(negedge clk);
        check("t5_idle", 32'(stall), 32'd0);
        check("t5_drained_beats", 32'(n_rbeats - b0), 32'd2);
        ar_dly = 0;

        // foreign-id beats interleaved with the burst
        foreign_pct = 60;
        issue(32'h1C000500);
        wait_valid(80);
        check("t6_pc", out_pc, 32'h1C000500);
        check("t6_inst0", out_inst0, mem_word(32'h1C000500));
        wait_idle(10);
        foreign_pct = 0;

        // asynchronous reset in R1
        issue(32'h1C000400);
        tick();
        tick();
        #2;
        check("t6_rready_r1", 32'(rready), 32'd1);
        rst = 1'b1;
        #1;
        check("ar_stall", 32'(stall), 32'd0);
        check("ar_rready", 32'(rready), 32'd0);
        check("ar_arvalid", 32'(arvalid), 32'd0);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_pc", out_pc, 32'd0);
        check("ar_out_inst0", out_inst0, 32'd0);
        check("ar_araddr", araddr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(32'h1C000600);
        wait_valid(20);
        check("post_rst_pc", out_pc, 32'h1C000600);
        wait_idle(10);

        // randomized traffic
        tick();
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) begin
                ar_dly      = int'($urandom_range(0, 3));
                gap_pct     = int'($urandom_range(0, 40));
                foreign_pct = int'($urandom_range(0, 20));
            end
            r = $urandom();
            if ($urandom_range(0, 99) < 15) r[0] = 1'b1;
            else r[1:0] = 2'b00;
            pc        = r;
            inst_rreq = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) < 5);
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        inst_rreq = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wait_idle(200);
        check("end_out_valid", 32'(out_valid), 32'd0);
        check("end_rready", 32'(rready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
